// File: rtl/snn_layer_delay_lif.sv
// snn_layer_delay_lif: one layer of N leaky integrate-and-fire neurons driven by
// M spike inputs through signed per-synapse weights. Each input owns a tapped
// history register shared by all neurons; every synapse can pick the live spike
// or one history tap. Optional build macro SNN_LAYER_MEMBRANE_DEBUG_EN exposes
// the membrane registers on membrane_potential_out (tied to 0 otherwise).
module snn_layer_delay_lif #(
  parameter int M  = 2,
  parameter int N  = 4,
  parameter int WW = 3,
  parameter int VW = 6,
  parameter int DW = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                delay_tick,
  input  logic [M-1:0]        input_spikes,
  input  logic [N*M*WW-1:0]   weights,
  input  logic [VW-2:0]       threshold,
  input  logic [VW-2:0]       decay,
  input  logic [4:0]          refractory_period,
  input  logic [N*M*DW-1:0]   delay_values,
  input  logic [N*M-1:0]      delays,
  output logic [N*VW-1:0]     membrane_potential_out,
  output logic [N-1:0]        output_spikes
);
  localparam int D  = 2 ** DW;
  // Sum width: enough headroom for M weights of WW bits, signed.
  localparam int SW = WW + $clog2(M) + 1;
  // Working width for leak/add/saturate; wide enough that nothing wraps.
  localparam int EW = ((VW > SW) ? VW : SW) + 2;
  localparam logic signed [EW-1:0] VMAX = {{(EW-VW+1){1'b0}}, {(VW-1){1'b1}}};
  localparam logic signed [EW-1:0] VMIN = {{(EW-VW+1){1'b1}}, {(VW-1){1'b0}}};

  logic [D-1:0]          r_hist [M];
  logic signed [VW-1:0]  r_v    [N];
  logic [4:0]            r_cnt  [N];
  logic [N-1:0]          r_spk;

  logic [N*M-1:0]        w_eff;
  logic signed [SW-1:0]  w_sum  [N];
  logic signed [EW-1:0]  w_vext [N];
  logic signed [EW-1:0]  w_leak [N];
  logic signed [EW-1:0]  w_cand [N];
  logic signed [EW-1:0]  w_clip [N];
  logic [N-1:0]          w_fire;
  logic signed [EW-1:0]  w_dec;
  logic signed [EW-1:0]  w_thr;

  assign w_dec = {{(EW-VW+1){1'b0}}, decay};
  assign w_thr = {{(EW-VW+1){1'b0}}, threshold};

  // Effective spike per synapse: live input, or the selected tap of that input's history.
  always_comb begin
    w_eff = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        if (delays[i*M+j]) begin
          w_eff[i*M+j] = r_hist[j][delay_values[(i*M+j)*DW +: DW]];
        end else begin
          w_eff[i*M+j] = input_spikes[j];
        end
      end
    end
  end

  // Synaptic sum, leak toward zero, saturated candidate potential and fire decision.
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < N; i++) begin
      w_sum[i]  = '0;
      w_vext[i] = '0;
      w_leak[i] = '0;
      w_cand[i] = '0;
      w_clip[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        if (w_eff[i*M+j]) begin
          w_sum[i] = w_sum[i] + {{(SW-WW){weights[(i*M+j)*WW+WW-1]}}, weights[(i*M+j)*WW +: WW]};
        end else begin
          w_sum[i] = w_sum[i];
        end
      end
      w_vext[i] = {{(EW-VW){r_v[i][VW-1]}}, r_v[i]};
      if (w_vext[i] > w_dec) begin
        w_leak[i] = w_vext[i] - w_dec;
      end else if (w_vext[i] < -w_dec) begin
        w_leak[i] = w_vext[i] + w_dec;
      end else begin
        w_leak[i] = '0;
      end
      w_cand[i] = w_leak[i] + {{(EW-SW){w_sum[i][SW-1]}}, w_sum[i]};
      if (w_cand[i] > VMAX) begin
        w_clip[i] = VMAX;
      end else if (w_cand[i] < VMIN) begin
        w_clip[i] = VMIN;
      end else begin
        w_clip[i] = w_cand[i];
      end
      if (w_clip[i] >= w_thr) begin
        w_fire[i] = 1'b1;
      end else begin
        w_fire[i] = 1'b0;
      end
    end
  end

  // History shift, per-neuron integrate/refractory update and registered spikes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < M; j++) begin
        r_hist[j] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        r_v[i]   <= '0;
        r_cnt[i] <= 5'd0;
      end
      r_spk <= '0;
    end else if (enable) begin
      if (delay_tick) begin
        for (int j = 0; j < M; j++) begin
          r_hist[j] <= {r_hist[j][D-2:0], input_spikes[j]};
        end
      end
      for (int i = 0; i < N; i++) begin
        if (r_cnt[i] != 5'd0) begin
          // Refractory: ignore inputs, pin V at 0 and count down.
          r_cnt[i] <= r_cnt[i] - 5'd1;
          r_v[i]   <= '0;
          r_spk[i] <= 1'b0;
        end else if (w_fire[i]) begin
          r_spk[i] <= 1'b1;
          r_v[i]   <= '0;
          r_cnt[i] <= refractory_period;
        end else begin
          r_spk[i] <= 1'b0;
          r_v[i]   <= w_clip[i][VW-1:0];
        end
      end
    end else begin
      r_spk <= '0;
    end
  end

`ifdef SNN_LAYER_MEMBRANE_DEBUG_EN
  // Expose the registered membrane potential of every neuron.
  always_comb begin
    membrane_potential_out = '0;
    for (int i = 0; i < N; i++) begin
      membrane_potential_out[i*VW +: VW] = r_v[i];
    end
  end
`else
  assign membrane_potential_out = '0;
`endif

  assign output_spikes = r_spk;

endmodule
